// File: rtl/fft_agu_ctrl.sv
// Address-generation and sequencing FSM for an in-place radix-2 DIT FFT.
// Issues butterfly reads per stage, delays them to form write-back, and ping-pongs banks.
module fft_agu_ctrl #(
  parameter int N_LOG2  = 4,
  parameter int BFU_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] stage,
  output logic [N_LOG2-1:0] rd_addrA,
  output logic [N_LOG2-1:0] rd_addrB,
  output logic [N_LOG2-2:0] twiddle_idx,
  output logic              in_valid,
  output logic              bank_sel,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addrA,
  output logic [N_LOG2-1:0] wr_addrB,
  output logic              wr_bank,
  output logic              result_bank
);

  // state | meaning
  // IDLE  | waiting for start
  // ISSUE | one butterfly issued per cycle, k = 0..N/2-1
  // DRAIN | BFU_LAT idle cycles so the last write lands before the next stage reads
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int DW = (BFU_LAT > 1) ? $clog2(BFU_LAT) : 1;
  localparam logic [DW-1:0]     D_INIT = DW'(BFU_LAT - 1);
  localparam logic [N_LOG2-2:0] K_LAST = '1;
  localparam logic [N_LOG2-2:0] K_ONE  = (N_LOG2-1)'(1);
  localparam logic [N_LOG2-1:0] S_LAST = N_LOG2'(N_LOG2 - 1);
  localparam logic [N_LOG2-1:0] S_ONE  = N_LOG2'(1);

  state_t            state, state_nxt;
  logic [N_LOG2-1:0] s, s_nxt;
  logic [N_LOG2-2:0] k, k_nxt;
  logic [DW-1:0]     d, d_nxt;
  logic              busy_nxt;
  logic [N_LOG2-1:0] a_nxt, b_nxt;
  logic [N_LOG2-2:0] tw_nxt;

  logic              pv  [BFU_LAT];
  logic [N_LOG2-1:0] pa  [BFU_LAT];
  logic [N_LOG2-1:0] pb  [BFU_LAT];
  logic              pbk [BFU_LAT];

  // Insert a 0 at bit position st of the butterfly index.
  function automatic logic [N_LOG2-1:0] addr_a(input logic [N_LOG2-1:0] st,
                                               input logic [N_LOG2-2:0] kk);
    logic [N_LOG2-1:0] kw, half, j;
    kw   = {1'b0, kk};
    half = S_ONE << st;
    j    = kw & (half - S_ONE);
    return ((kw >> st) << (st + S_ONE)) | j;
  endfunction

  function automatic logic [N_LOG2-2:0] tw_idx(input logic [N_LOG2-1:0] st,
                                               input logic [N_LOG2-2:0] kk);
    logic [N_LOG2-1:0] kw, half, j, t;
    kw   = {1'b0, kk};
    half = S_ONE << st;
    j    = kw & (half - S_ONE);
    t    = j << (S_LAST - st);
    return t[N_LOG2-2:0];
  endfunction

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    k_nxt     = k;
    d_nxt     = d;
    case (state)
      IDLE: if (start) begin
        state_nxt = ISSUE;
        s_nxt     = '0;
        k_nxt     = '0;
      end
      ISSUE: if (k == K_LAST) begin
        state_nxt = DRAIN;
        d_nxt     = D_INIT;
      end else begin
        k_nxt = k + K_ONE;
      end
      DRAIN: if (d == '0) begin
        if (s != S_LAST) begin
          state_nxt = ISSUE;
          s_nxt     = s + S_ONE;
          k_nxt     = '0;
        end else begin
          state_nxt = DONE;
        end
      end else begin
        d_nxt = d - DW'(1);
      end
      DONE: begin
        state_nxt = IDLE;
        s_nxt     = '0;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      s_nxt     = '0;
      k_nxt     = '0;
      d_nxt     = '0;
    end
    busy_nxt = (state_nxt == ISSUE) || (state_nxt == DRAIN);
    a_nxt    = addr_a(s_nxt, k_nxt);
    b_nxt    = a_nxt | (S_ONE << s_nxt);
    tw_nxt   = tw_idx(s_nxt, k_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s           <= '0;
      k           <= '0;
      d           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_valid    <= 1'b0;
      stage       <= '0;
      bank_sel    <= 1'b0;
      rd_addrA    <= '0;
      rd_addrB    <= '0;
      twiddle_idx <= '0;
      for (int i = 0; i < BFU_LAT; i++) begin
        pv[i]  <= 1'b0;
        pa[i]  <= '0;
        pb[i]  <= '0;
        pbk[i] <= 1'b0;
      end
    end else begin
      state    <= state_nxt;
      s        <= s_nxt;
      k        <= k_nxt;
      d        <= d_nxt;
      busy     <= busy_nxt;
      done     <= (state_nxt == DONE);
      in_valid <= (state_nxt == ISSUE);
      stage    <= busy_nxt ? s_nxt : '0;
      bank_sel <= busy_nxt ? s_nxt[0] : 1'b0;
      if (state_nxt == ISSUE) begin
        rd_addrA    <= a_nxt;
        rd_addrB    <= b_nxt;
        twiddle_idx <= tw_nxt;
      end
      // Write-back delay line; abort kills everything still in flight.
      pv[0]  <= in_valid & ~abort;
      pa[0]  <= rd_addrA;
      pb[0]  <= rd_addrB;
      pbk[0] <= ~bank_sel;
      for (int i = 1; i < BFU_LAT; i++) begin
        pv[i]  <= pv[i-1] & ~abort;
        pa[i]  <= pa[i-1];
        pb[i]  <= pb[i-1];
        pbk[i] <= pbk[i-1];
      end
    end
  end

  assign wr_en       = pv[BFU_LAT-1];
  assign wr_addrA    = pa[BFU_LAT-1];
  assign wr_addrB    = pb[BFU_LAT-1];
  assign wr_bank     = pbk[BFU_LAT-1];
  assign result_bank = ~S_LAST[0];

endmodule

// File: tb/tb_fft_agu_ctrl.sv
// Scoreboard bench for fft_agu_ctrl (N_LOG2=4, BFU_LAT=3): expected reads/writes/done queued at start.
module tb_fft_agu_ctrl;
  localparam int NL = 4;
  localparam int BL = 3;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic busy, done, in_valid, bank_sel, wr_en, wr_bank, result_bank;
  logic [NL-1:0] stage, rd_addrA, rd_addrB, wr_addrA, wr_addrB;
  logic [NL-2:0] twiddle_idx;

  fft_agu_ctrl #(.N_LOG2(NL), .BFU_LAT(BL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .stage(stage),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .twiddle_idx(twiddle_idx),
    .in_valid(in_valid), .bank_sel(bank_sel),
    .wr_en(wr_en), .wr_addrA(wr_addrA), .wr_addrB(wr_addrB), .wr_bank(wr_bank),
    .result_bank(result_bank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int a; int b; int tw; int st; int bank;} ev_t;
  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];

  int n_tests = 0, n_fail = 0;
  int cnt_iv = 0, cnt_we = 0, cnt_busy = 0, cnt_done = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected transactions for a full FFT whose start is high during cycle t0.
  task automatic push_run(input int t0);
    for (int s = 0; s < NL; s++) begin
      for (int k = 0; k < 8; k++) begin
        int half, lo, hi, a, ic;
        half = 1 << s;
        lo   = k % half;
        hi   = k / half;
        a    = hi * 2 * half + lo;
        ic   = t0 + 1 + s * (8 + BL) + k;
        rd_q.push_back('{ic, a, a + half, lo * (8 / half), s, s % 2});
        wr_q.push_back('{ic + BL, a, a + half, 0, s, 1 - (s % 2)});
      end
    end
    done_q.push_back(t0 + 1 + NL * (8 + BL));
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (busy) cnt_busy++;
      if (in_valid) begin
        cnt_iv++;
        if (rd_q.size() == 0) check("rd_unexpected", cyc, -1);
        else begin
          e = rd_q.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_addrA", int'(rd_addrA), e.a);
          check("rd_addrB", int'(rd_addrB), e.b);
          check("twiddle", int'(twiddle_idx), e.tw);
          check("stage", int'(stage), e.st);
          check("bank_sel", int'(bank_sel), e.bank);
        end
      end
      if (wr_en) begin
        cnt_we++;
        if (wr_q.size() == 0) check("wr_unexpected", cyc, -1);
        else begin
          e = wr_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addrA", int'(wr_addrA), e.a);
          check("wr_addrB", int'(wr_addrB), e.b);
          check("wr_bank", int'(wr_bank), e.bank);
        end
      end
      if (done) begin
        cnt_done++;
        if (done_q.size() == 0) check("done_unexpected", cyc, -1);
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_at(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic start_run(output int t0);
    start = 1'b1;
    t0 = cyc;
    push_run(t0);
    cnt_iv = 0; cnt_we = 0; cnt_busy = 0; cnt_done = 0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_full_counts(input string tag);
    check({tag, "_in_valid_count"}, cnt_iv, 32);
    check({tag, "_wr_en_count"}, cnt_we, 32);
    check({tag, "_busy_cycles"}, cnt_busy, 44);
    check({tag, "_done_count"}, cnt_done, 1);
    check({tag, "_queues_left"}, rd_q.size() + wr_q.size() + done_q.size(), 0);
  endtask

  int t0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_in_valid", int'(in_valid), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_done", int'(done), 0);
    check("result_bank", int'(result_bank), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full run with ignored start pulses at cycles 10 and 45.
    start_run(t0);
    sample_at(t0 + 1);
    check("c1_busy", int'(busy), 1);
    check("c1_in_valid", int'(in_valid), 1);
    check("c1_A", int'(rd_addrA), 0);
    check("c1_B", int'(rd_addrB), 1);
    check("c1_tw", int'(twiddle_idx), 0);
    sample_at(t0 + 2);
    check("c2_A", int'(rd_addrA), 2);
    check("c2_B", int'(rd_addrB), 3);
    sample_at(t0 + 4);
    check("c4_wr_en", int'(wr_en), 1);
    check("c4_wrA", int'(wr_addrA), 0);
    check("c4_wrB", int'(wr_addrB), 1);
    check("c4_wr_bank", int'(wr_bank), 1);
    goto(t0 + 10);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sample_at(t0 + 28);
    check("s2k5_A", int'(rd_addrA), 9);
    check("s2k5_B", int'(rd_addrB), 13);
    check("s2k5_tw", int'(twiddle_idx), 2);
    check("s2k5_bank", int'(bank_sel), 0);
    sample_at(t0 + 41);
    check("s3k7_A", int'(rd_addrA), 7);
    check("s3k7_B", int'(rd_addrB), 15);
    check("s3k7_tw", int'(twiddle_idx), 7);
    check("s3k7_bank", int'(bank_sel), 1);
    sample_at(t0 + 44);
    check("c44_busy", int'(busy), 1);
    check("c44_wr_bank", int'(wr_bank), 0);
    goto(t0 + 45);
    start = 1'b1;
    @(negedge clk);
    check("c45_done", int'(done), 1);
    check("c45_busy", int'(busy), 0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("c46_busy", int'(busy), 0);
    check("c46_done", int'(done), 0);
    sample_at(t0 + 47);
    check("c47_in_valid", int'(in_valid), 0);
    check_full_counts("run1");

    // Abort in stage 1 ISSUE with a simultaneous start.
    @(posedge clk);
    #1;
    start_run(t0);
    goto(t0 + 15);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_in_valid", int'(in_valid), 0);
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_stage", int'(stage), 0);
    sample_at(t0 + 60);
    check("abort_iv_count", cnt_iv, 12);
    check("abort_we_count", cnt_we, 9);
    check("abort_done_count", cnt_done, 0);

    @(posedge clk);
    #1;
    start_run(t0);
    goto(t0 + 47);
    check_full_counts("run2");

    // Async reset in stage 0 DRAIN while a write is in flight.
    start_run(t0);
    goto(t0 + 10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_in_valid", int'(in_valid), 0);
    check("arst_wr_en", int'(wr_en), 0);
    check("arst_wrA", int'(wr_addrA), 0);
    check("arst_bank_sel", int'(bank_sel), 0);
    check("arst_rdA", int'(rd_addrA), 0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt_iv = 0; cnt_we = 0; cnt_busy = 0; cnt_done = 0;
    repeat (20) @(posedge clk);
    #1;
    check("arst_after_we", cnt_we, 0);
    check("arst_after_iv", cnt_iv, 0);
    check("arst_after_busy", cnt_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
